// File: rtl/branch_flush_ctrl.sv
// Control-flow sequencer for an in-order IF/ID/EX pipeline using predict-not-taken.
// Tracks branches and jumps from ID into EX, then issues the PC redirect, the flush window and the perf counters.
module branch_flush_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             hold_in,
  output logic             abd_sel,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  typedef enum logic [1:0] {RUN, RESOLVE, JUMP, FLUSH} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state, state_nx;
  logic [2:0]       flush_cnt, flush_cnt_nx;
  logic             redirect_valid_nx, flush_nx;
  logic [31:0]      redirect_pc_nx;
  logic [CNT_W-1:0] br_cnt_nx, taken_cnt_nx, jump_cnt_nx;
  logic             id_branch, id_jump;
  logic             unused_inst_bits;

  // The upper instruction bits carry no control-flow information here.
  assign unused_inst_bits = ^id_inst[31:7];

  assign id_branch = id_valid && (id_inst[6:0] == OP_BRANCH);
  assign id_jump   = id_valid && ((id_inst[6:0] == OP_JAL) || (id_inst[6:0] == OP_JALR));
  assign abd_sel   = (state == RESOLVE);

  always_comb begin
    state_nx          = state;
    flush_cnt_nx      = flush_cnt;
    redirect_valid_nx = redirect_valid;
    redirect_pc_nx    = redirect_pc;
    flush_nx          = flush_if;
    br_cnt_nx         = br_cnt;
    taken_cnt_nx      = taken_cnt;
    jump_cnt_nx       = jump_cnt;
    // A hold freezes everything, including a pending redirect pulse.
    if (!hold_in) begin
      redirect_valid_nx = 1'b0;
      redirect_pc_nx    = '0;
      case (state)
        RUN: begin
          if (id_branch)    state_nx = RESOLVE;
          else if (id_jump) state_nx = JUMP;
        end
        RESOLVE: begin
          br_cnt_nx = br_cnt + CNT_W'(1);
          if (ex_taken) begin
            taken_cnt_nx      = taken_cnt + CNT_W'(1);
            redirect_valid_nx = 1'b1;
            redirect_pc_nx    = ex_target;
            flush_nx          = 1'b1;
            flush_cnt_nx      = FLUSH_LOAD;
            state_nx          = FLUSH;
          end else if (id_branch) begin
            state_nx = RESOLVE;
          end else if (id_jump) begin
            state_nx = JUMP;
          end else begin
            state_nx = RUN;
          end
        end
        JUMP: begin
          jump_cnt_nx       = jump_cnt + CNT_W'(1);
          redirect_valid_nx = 1'b1;
          redirect_pc_nx    = ex_target;
          flush_nx          = 1'b1;
          flush_cnt_nx      = FLUSH_LOAD;
          state_nx          = FLUSH;
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            flush_nx = 1'b0;
            state_nx = RUN;
          end else begin
            flush_cnt_nx = flush_cnt - 3'd1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      br_cnt         <= '0;
      taken_cnt      <= '0;
      jump_cnt       <= '0;
    end else begin
      state          <= state_nx;
      flush_cnt      <= flush_cnt_nx;
      redirect_valid <= redirect_valid_nx;
      redirect_pc    <= redirect_pc_nx;
      flush_if       <= flush_nx;
      flush_id       <= flush_nx;
      br_cnt         <= br_cnt_nx;
      taken_cnt      <= taken_cnt_nx;
      jump_cnt       <= jump_cnt_nx;
    end
  end

endmodule

// File: doc/branch_flush_ctrl.md
Name: branch_flush_ctrl

Overview:
- Control-flow sequencer for the in-order RISC-V pipeline (IF/ID/EX); predict-not-taken throughout.
- Detects branches (opcode 1100011) and jumps (JAL 1101111, JALR 1100111) in ID and tracks each into EX.
- Drives the branch-operand select (abd_sel) for the EX operand mux.
- Issues the PC redirect and the IF/ID flush bubbles, and keeps control-flow performance counters.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles flush_if/flush_id stay asserted after a redirect; legal range 1..7.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_inst  input  32  instruction currently in ID
id_valid  input  1  id_inst holds a real instruction
ex_taken  input  1  branch comparator result for the instruction in EX; sampled only in RESOLVE
ex_target  input  32  branch/jump target computed in EX; sampled in RESOLVE and JUMP
hold_in  input  1  pipeline-wide stall; freezes this block
abd_sel  output  1  1 = operand mux selects branch operand path (input2), 0 = input1
redirect_valid  output  1  PC redirect request
redirect_pc  output  32  redirect target
flush_if  output  1  squash IF instruction
flush_id  output  1  squash ID instruction
br_cnt  output  CNT_W  branches resolved
taken_cnt  output  CNT_W  branches taken
jump_cnt  output  CNT_W  jumps executed

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately:
  - state = RUN.
  - All outputs 0, redirect_pc = 0, counters 0, flush counter 0.
  - Reset mid-sequence abandons any pending redirect or flush.
- States: RUN, RESOLVE, JUMP, FLUSH. Registered state. All outputs are registered except abd_sel = (state == RESOLVE).
- Detection: when id_valid=1 and hold_in=0, ID opcode id_inst[6:0] is classified as branch, jump, or other.
- RUN:
  - ID branch -> RESOLVE.
  - ID jump -> JUMP.
  - Otherwise stay in RUN.
- RESOLVE (branch in EX, abd_sel=1):
  - br_cnt += 1.
  - ex_taken=1:
    - taken_cnt += 1.
    - Next cycle: redirect_valid=1, redirect_pc=ex_target, flush_if=flush_id=1.
    - Flush counter loads FLUSH_CYCLES-1; state -> FLUSH.
  - ex_taken=0: evaluate ID in the same cycle exactly as in RUN (back-to-back branch or jump is legal).
- JUMP:
  - jump_cnt += 1; ex_taken is ignored.
  - Redirect and flush exactly as for a taken branch; state -> FLUSH.
  - The ID instruction is ignored because it will be flushed.
- FLUSH:
  - flush_if/flush_id stay high; counter decrements each unheld cycle.
  - On the cycle the counter is 0, flushes deassert at the next edge and state -> RUN.
  - ID is ignored throughout.
  - With FLUSH_CYCLES=1, flushes last exactly one cycle.
- redirect_valid:
  - One-cycle pulse when hold_in=0.
  - If hold_in=1 while asserted, it and redirect_pc stay asserted until the first cycle with hold_in=0, then clear.
- hold_in=1 freezes state, flush counter, counters and all registered outputs. No detection occurs while held.
- Latency: branch/jump in ID at cycle N -> redirect and first flush at cycle N+2 (no holds).
- Counters wrap modulo 2^CNT_W.
- Opcodes other than the three listed are never control flow. id_valid=0 is treated as other.

Test Plan:
- Reset: assert rst_n=0 mid-FLUSH -> state RUN, all outputs 0 immediately. Counters read 0 after release.
- Not-taken branch: id_inst=0x00208463 at N, ex_taken=0 -> abd_sel=1 at N+1 only, no redirect/flush, br_cnt=1, taken_cnt=0.
- Taken branch: same instruction, ex_taken=1, ex_target=0x00000040 -> at N+2 redirect_valid=1 for one cycle with redirect_pc=0x00000040. flush_if/flush_id high N+2..N+3. RUN at N+4. taken_cnt=1.
- JAL: id_inst=0x0100006F, ex_taken=0, ex_target=0x00000100 -> redirect to 0x100 at N+2, abd_sel stays 0, jump_cnt=1. Repeat with JALR 0x000080E7 -> same response.
- Back-to-back: not-taken branch at N, then branch in ID at N+1 with ex_taken=1 at N+2 -> RESOLVE at N+1 and N+2, redirect at N+3, br_cnt=2, taken_cnt=1.
- Hold: hold_in=1 on the redirect cycle for 3 cycles -> redirect_valid stays 1 for 4 cycles total; the flush window extends by 3 cycles.
